// File: rtl/down_count_wrap_monitor.sv
// Wrap monitor for a down counter: flags each 0 -> all-ones transition, counts wraps and buffers one wrap event.
// Optional feature macro WRAP_MON_STEP_CHECK_EN adds a sticky check for illegal counter steps.
module down_count_wrap_monitor #(
  parameter int W  = 4,
  parameter int CW = 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_en,
  input  logic          i_clr,
  input  logic [W-1:0]  i_cnt_in,
  output logic          o_tc_pulse,
  output logic [CW-1:0] o_wrap_cnt,
  output logic          o_evt_valid,
  input  logic          i_evt_ready,
  output logic [CW-1:0] o_evt_data,
  output logic          o_overflow,
  output logic          o_err_step
);

  typedef enum logic {
    S_INIT  = 1'b0,
    S_TRACK = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [W-1:0]  r_prev;
  logic          r_tc_pulse;
  logic [CW-1:0] r_wrap_cnt;
  logic          r_evt_valid;
  logic [CW-1:0] r_evt_data;
  logic          r_overflow;
  logic          w_wrap;
  logic          w_drain;
  logic [CW-1:0] w_wrap_cnt_inc;

  always_comb begin
    w_state_next = r_state;
    if (i_clr || !i_en) begin
      w_state_next = S_INIT;
    end else begin
      w_state_next = S_TRACK;
    end
  end

  assign w_wrap         = (r_state == S_TRACK) && i_en && (r_prev == '0) && (i_cnt_in == {W{1'b1}});
  assign w_drain        = r_evt_valid && i_evt_ready;
  assign w_wrap_cnt_inc = r_wrap_cnt + CW'(1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_INIT;
      r_prev  <= '0;
    end else begin
      r_state <= w_state_next;
      if (i_en && !i_clr) begin
        r_prev <= i_cnt_in;
      end
    end
  end

  // clr has priority over a coincident wrap or drain
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tc_pulse  <= 1'b0;
      r_wrap_cnt  <= '0;
      r_evt_valid <= 1'b0;
      r_evt_data  <= '0;
      r_overflow  <= 1'b0;
    end else if (i_clr) begin
      r_tc_pulse  <= 1'b0;
      r_wrap_cnt  <= '0;
      r_evt_valid <= 1'b0;
      r_evt_data  <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_tc_pulse <= w_wrap;
      if (w_wrap) begin
        r_wrap_cnt <= w_wrap_cnt_inc;
        if (!r_evt_valid || w_drain) begin
          r_evt_valid <= 1'b1;
          r_evt_data  <= w_wrap_cnt_inc;
        end else begin
          r_overflow <= 1'b1;
        end
      end else if (w_drain) begin
        r_evt_valid <= 1'b0;
      end
    end
  end

`ifdef WRAP_MON_STEP_CHECK_EN
  logic w_step_err;
  logic r_err_step;

  assign w_step_err = (r_state == S_TRACK) && i_en && (i_cnt_in != r_prev) &&
                      (i_cnt_in != (r_prev - W'(1)));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_err_step <= 1'b0;
    end else if (i_clr) begin
      r_err_step <= 1'b0;
    end else if (w_step_err) begin
      r_err_step <= 1'b1;
    end
  end

  assign o_err_step = r_err_step;
`else
  assign o_err_step = 1'b0;
`endif

  assign o_tc_pulse  = r_tc_pulse;
  assign o_wrap_cnt  = r_wrap_cnt;
  assign o_evt_valid = r_evt_valid;
  assign o_evt_data  = r_evt_data;
  assign o_overflow  = r_overflow;

endmodule

// File: tb/tb_down_count_wrap_monitor.sv
// Self-checking bench for down_count_wrap_monitor: table-driven vectors through an expected-result queue.
module tb_down_count_wrap_monitor;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       clr;
  logic [3:0] cnt_in;
  logic       tc_pulse;
  logic [7:0] wrap_cnt;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_data;
  logic       overflow;
  logic       err_step;

  typedef struct packed {
    logic       tc;
    logic [7:0] wc;
    logic       v;
    logic [7:0] d;
    logic       ov;
    logic       err;
  } outs_t;

  typedef struct packed {
    logic       en;
    logic       clr;
    logic [3:0] cnt;
    logic       rdy;
    outs_t      exp;
  } vec_t;

  vec_t  vecs[$];
  outs_t sb[$];
  int    checks   = 0;
  int    failures = 0;

  down_count_wrap_monitor #(.W(4), .CW(8)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_en        (en),
    .i_clr       (clr),
    .i_cnt_in    (cnt_in),
    .o_tc_pulse  (tc_pulse),
    .o_wrap_cnt  (wrap_cnt),
    .o_evt_valid (evt_valid),
    .i_evt_ready (evt_ready),
    .o_evt_data  (evt_data),
    .o_overflow  (overflow),
    .o_err_step  (err_step)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // err_step expectations only hold when the step checker is compiled in
  task automatic addVec(input logic e, input logic c, input logic [3:0] n, input logic r,
                        input logic tc, input logic [7:0] wc, input logic v,
                        input logic [7:0] d, input logic ov, input logic er);
    vec_t x;
    x.en  = e;
    x.clr = c;
    x.cnt = n;
    x.rdy = r;
    x.exp.tc = tc;
    x.exp.wc = wc;
    x.exp.v  = v;
    x.exp.d  = d;
    x.exp.ov = ov;
`ifdef WRAP_MON_STEP_CHECK_EN
    x.exp.err = er;
`else
    x.exp.err = 1'b0 & er;
`endif
    vecs.push_back(x);
  endtask

  task automatic checkOutput(input string name, input outs_t exp);
    outs_t act;
    act = '{tc: tc_pulse, wc: wrap_cnt, v: evt_valid, d: evt_data, ov: overflow, err: err_step};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got tc=%0b wc=%0d v=%0b d=%0d ov=%0b err=%0b, want tc=%0b wc=%0d v=%0b d=%0d ov=%0b err=%0b",
               name, act.tc, act.wc, act.v, act.d, act.ov, act.err,
               exp.tc, exp.wc, exp.v, exp.d, exp.ov, exp.err);
    end
  endtask

  // drive on the falling edge, compare 1 time unit after the rising edge
  task automatic applyStimulus(input vec_t x);
    @(negedge clk);
    en        = x.en;
    clr       = x.clr;
    cnt_in    = x.cnt;
    evt_ready = x.rdy;
    sb.push_back(x.exp);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL scoreboard: got empty queue, want one entry");
    end else begin
      checkOutput("vector", sb.pop_front());
    end
  endtask

  initial begin
    outs_t zero;
    zero = '0;
    rst_n = 1'b0;
    en = 1'b1;
    clr = 1'b0;
    cnt_in = 4'd5;
    evt_ready = 1'b0;

    //       en clr cnt rdy | tc wc v d ov err
    addVec(0, 0, 4'd5,  0,  0, 0, 0, 0, 0, 0);
    addVec(1, 0, 4'd3,  0,  0, 0, 0, 0, 0, 0);
    addVec(1, 0, 4'd2,  0,  0, 0, 0, 0, 0, 0);
    addVec(1, 0, 4'd1,  0,  0, 0, 0, 0, 0, 0);
    addVec(1, 0, 4'd0,  0,  0, 0, 0, 0, 0, 0);
    addVec(1, 0, 4'd15, 0,  1, 1, 1, 1, 0, 0);
    addVec(1, 0, 4'd15, 0,  0, 1, 1, 1, 0, 0);
    addVec(1, 0, 4'd14, 0,  0, 1, 1, 1, 0, 0);
    addVec(0, 0, 4'd0,  0,  0, 1, 1, 1, 0, 0);
    addVec(1, 0, 4'd0,  0,  0, 1, 1, 1, 0, 0);
    addVec(1, 0, 4'd15, 0,  1, 2, 1, 1, 1, 0);
    addVec(1, 0, 4'd15, 1,  0, 2, 0, 1, 1, 0);
    addVec(0, 1, 4'd0,  0,  0, 0, 0, 0, 0, 0);
    addVec(1, 0, 4'd0,  0,  0, 0, 0, 0, 0, 0);
    addVec(1, 0, 4'd15, 0,  1, 1, 1, 1, 0, 0);
    addVec(0, 0, 4'd0,  0,  0, 1, 1, 1, 0, 0);
    addVec(1, 0, 4'd0,  0,  0, 1, 1, 1, 0, 0);
    addVec(1, 0, 4'd15, 1,  1, 2, 1, 2, 0, 0);
    addVec(0, 0, 4'd0,  0,  0, 2, 1, 2, 0, 0);
    addVec(1, 0, 4'd0,  0,  0, 2, 1, 2, 0, 0);
    addVec(1, 1, 4'd15, 1,  0, 0, 0, 0, 0, 0);
    addVec(1, 0, 4'd0,  0,  0, 0, 0, 0, 0, 0);
    addVec(0, 0, 4'd15, 0,  0, 0, 0, 0, 0, 0);
    addVec(1, 0, 4'd15, 0,  0, 0, 0, 0, 0, 0);
    addVec(0, 0, 4'd9,  0,  0, 0, 0, 0, 0, 0);
    addVec(1, 0, 4'd9,  0,  0, 0, 0, 0, 0, 0);
    addVec(1, 0, 4'd9,  0,  0, 0, 0, 0, 0, 0);
    addVec(1, 0, 4'd8,  0,  0, 0, 0, 0, 0, 0);
    addVec(1, 0, 4'd5,  0,  0, 0, 0, 0, 0, 1);
    addVec(1, 0, 4'd4,  0,  0, 0, 0, 0, 0, 1);
    addVec(0, 1, 4'd0,  0,  0, 0, 0, 0, 0, 0);
    addVec(0, 0, 4'd9,  0,  0, 0, 0, 0, 0, 0);
    addVec(1, 0, 4'd9,  0,  0, 0, 0, 0, 0, 0);
    addVec(1, 0, 4'd6,  0,  0, 0, 0, 0, 0, 1);
    addVec(1, 0, 4'd5,  0,  0, 0, 0, 0, 0, 1);
    addVec(0, 1, 4'd0,  0,  0, 0, 0, 0, 0, 0);
    addVec(1, 0, 4'd0,  0,  0, 0, 0, 0, 0, 0);
    addVec(1, 0, 4'd15, 0,  1, 1, 1, 1, 0, 0);

    // held in reset across several clock edges with sampling enabled
    repeat (3) @(posedge clk);
    #1;
    checkOutput("in_reset", zero);
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b0;

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // asynchronous reset between edges wipes a pending event
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", zero);
    #2;
    rst_n = 1'b1;
    en    = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("after_async_reset", zero);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
